// File: rtl/fpu_div_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : fpu_div_seq                                                |
// | Description : Multi-cycle IEEE-754 single-precision divider (fdiv.s).    |
// |               Radix-2 restoring division producing 26 quotient bits,     |
// |               round-to-nearest-even, subnormal operands and results      |
// |               flushed to zero. Stalls the core until the result is       |
// |               presented for exactly one cycle alongside DONE.            |
// | Ports       : CLK    - core clock, rising edge                           |
// |               RST    - synchronous active-low reset                      |
// |               START  - divide request, accepted only when idle           |
// |               OP_A   - dividend, captured with START                     |
// |               OP_B   - divisor, captured with START                      |
// |               STALL  - combinational hold request for PC/IF              |
// |               BUSY   - registered, high while a division is in flight    |
// |               DONE   - registered one-cycle completion pulse             |
// |               RESULT - quotient, valid only while DONE is high           |
// |               FLAGS  - {NV,DZ,OF,UF,NX}, valid only while DONE is high   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module fpu_div_seq #(
    parameter int unsigned BITS_PER_CYC = 1,            // 1 or 2
    parameter logic [31:0] QNAN         = 32'h7FC0_0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    input  logic [31:0] OP_A,
    input  logic [31:0] OP_B,
    output logic        STALL,
    output logic        BUSY,
    output logic        DONE,
    output logic [31:0] RESULT,
    output logic [4:0]  FLAGS
);

    localparam int unsigned c_QBITS    = 26;
    localparam logic [4:0]  c_LAST_CNT = 5'(c_QBITS / BITS_PER_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_DIV  = 3'd2,
        S_NORM = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [31:0]        r_a;
    logic [31:0]        r_b;
    logic               r_sign;
    logic signed [9:0]  r_exp;
    logic [23:0]        r_mb;
    logic [24:0]        r_rem;
    logic [25:0]        r_q;
    logic [4:0]         r_cnt;
    logic               r_busy;
    logic               r_done;
    logic [31:0]        r_result;
    logic [4:0]         r_flags;

    // ------------------------------------------------------------------
    // Operand unpack and special-case classification (used in PREP)
    // ------------------------------------------------------------------
    logic [7:0]         w_ea, w_eb;
    logic [22:0]        w_fa, w_fb;
    logic               w_sign;
    logic               w_a_nan, w_b_nan, w_a_snan, w_b_snan;
    logic               w_a_inf, w_b_inf, w_a_zero, w_b_zero;
    logic               w_special;
    logic signed [9:0]  w_exp_init;
    logic [31:0]        w_spec_res;
    logic [4:0]         w_spec_flags;

    assign w_ea     = r_a[30:23];
    assign w_eb     = r_b[30:23];
    assign w_fa     = r_a[22:0];
    assign w_fb     = r_b[22:0];
    assign w_sign   = r_a[31] ^ r_b[31];
    assign w_a_nan  = (w_ea == 8'hFF) && (w_fa != 23'd0);
    assign w_b_nan  = (w_eb == 8'hFF) && (w_fb != 23'd0);
    // A NaN with the quiet bit clear is signalling
    assign w_a_snan = w_a_nan && !w_fa[22];
    assign w_b_snan = w_b_nan && !w_fb[22];
    assign w_a_inf  = (w_ea == 8'hFF) && (w_fa == 23'd0);
    assign w_b_inf  = (w_eb == 8'hFF) && (w_fb == 23'd0);
    // Zero exponent covers subnormals too: they are flushed to signed zero
    assign w_a_zero = (w_ea == 8'h00);
    assign w_b_zero = (w_eb == 8'h00);
    assign w_special = w_a_nan | w_b_nan | w_a_inf | w_b_inf | w_a_zero | w_b_zero;
    assign w_exp_init = $signed({2'b00, w_ea}) - $signed({2'b00, w_eb}) + 10'sd127;

    always_comb begin
        w_spec_res   = {w_sign, 31'd0};
        w_spec_flags = 5'd0;
        if (w_a_nan || w_b_nan) begin
            w_spec_res      = QNAN;
            w_spec_flags[4] = w_a_snan | w_b_snan;
        end else if ((w_a_zero && w_b_zero) || (w_a_inf && w_b_inf)) begin
            w_spec_res      = QNAN;
            w_spec_flags[4] = 1'b1;
        end else if (w_b_zero) begin
            w_spec_res      = {w_sign, 8'hFF, 23'd0};
            w_spec_flags[3] = 1'b1;
        end else if (w_a_inf) begin
            w_spec_res      = {w_sign, 8'hFF, 23'd0};
        end
        // Remaining specials are 0/x and x/inf: signed zero (the default)
    end

    // ------------------------------------------------------------------
    // Restoring division step, BITS_PER_CYC quotient bits per cycle
    // ------------------------------------------------------------------
    logic [24:0] w_rem_nxt;
    logic [25:0] w_q_nxt;

    always_comb begin
        w_rem_nxt = r_rem;
        w_q_nxt   = r_q;
        for (int i = 0; i < int'(BITS_PER_CYC); i++) begin
            if (w_rem_nxt >= {1'b0, r_mb}) begin
                w_rem_nxt = (w_rem_nxt - {1'b0, r_mb}) << 1;
                w_q_nxt   = {w_q_nxt[24:0], 1'b1};
            end else begin
                w_rem_nxt = w_rem_nxt << 1;
                w_q_nxt   = {w_q_nxt[24:0], 1'b0};
            end
        end
    end

    // ------------------------------------------------------------------
    // Normalise, round to nearest even, range check (used in NORM)
    // ------------------------------------------------------------------
    logic [22:0]        w_man;
    logic               w_g, w_s, w_inc;
    logic [23:0]        w_man_rnd;
    logic signed [9:0]  w_exp_n, w_exp_r;
    logic [31:0]        w_norm_res;
    logic [4:0]         w_norm_flags;

    always_comb begin
        if (r_q[25]) begin
            w_man   = r_q[24:2];
            w_g     = r_q[1];
            w_s     = r_q[0] | (r_rem != 25'd0);
            w_exp_n = r_exp;
        end else begin
            w_man   = r_q[23:1];
            w_g     = r_q[0];
            w_s     = (r_rem != 25'd0);
            w_exp_n = r_exp - 10'sd1;
        end
        w_inc     = w_g & (w_s | w_man[0]);
        w_man_rnd = {1'b0, w_man} + {23'd0, w_inc};
        // Carry out of the fraction leaves it at zero and bumps the exponent
        w_exp_r   = w_man_rnd[23] ? (w_exp_n + 10'sd1) : w_exp_n;

        if (w_exp_r >= 10'sd255) begin
            w_norm_res   = {r_sign, 8'hFF, 23'd0};
            w_norm_flags = 5'b00101;
        end else if (w_exp_r <= 10'sd0) begin
            w_norm_res   = {r_sign, 31'd0};
            w_norm_flags = 5'b00011;
        end else begin
            w_norm_res   = {r_sign, w_exp_r[7:0], w_man_rnd[22:0]};
            w_norm_flags = {4'd0, w_g | w_s};
        end
    end

    // ------------------------------------------------------------------
    // Control: next state and stall
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        STALL       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (START) begin
                    w_state_nxt = S_PREP;
                    STALL       = 1'b1;
                end
            end
            S_PREP: begin
                STALL       = 1'b1;
                w_state_nxt = w_special ? S_DONE : S_DIV;
            end
            S_DIV: begin
                STALL = 1'b1;
                if (r_cnt == c_LAST_CNT) begin
                    w_state_nxt = S_NORM;
                end
            end
            S_NORM: begin
                STALL       = 1'b1;
                w_state_nxt = S_DONE;
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state  <= S_IDLE;
            r_a      <= 32'd0;
            r_b      <= 32'd0;
            r_sign   <= 1'b0;
            r_exp    <= 10'sd0;
            r_mb     <= 24'd0;
            r_rem    <= 25'd0;
            r_q      <= 26'd0;
            r_cnt    <= 5'd0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= 32'd0;
            r_flags  <= 5'd0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt == S_PREP) || (w_state_nxt == S_DIV) ||
                       (w_state_nxt == S_NORM);
            r_done  <= (w_state_nxt == S_DONE);
            case (r_state)
                S_IDLE: begin
                    if (START) begin
                        r_a <= OP_A;
                        r_b <= OP_B;
                    end
                end
                S_PREP: begin
                    r_sign <= w_sign;
                    if (w_special) begin
                        r_result <= w_spec_res;
                        r_flags  <= w_spec_flags;
                    end else begin
                        r_exp <= w_exp_init;
                        r_mb  <= {1'b1, w_fb};
                        r_rem <= {2'b01, w_fa};
                        r_q   <= 26'd0;
                        r_cnt <= 5'd0;
                    end
                end
                S_DIV: begin
                    r_rem <= w_rem_nxt;
                    r_q   <= w_q_nxt;
                    r_cnt <= r_cnt + 5'd1;
                end
                S_NORM: begin
                    r_result <= w_norm_res;
                    r_flags  <= w_norm_flags;
                end
                S_DONE: begin
                    r_result <= 32'd0;
                    r_flags  <= 5'd0;
                end
                default: ;
            endcase
        end
    end

    assign BUSY   = r_busy;
    assign DONE   = r_done;
    assign RESULT = r_result;
    assign FLAGS  = r_flags;

endmodule
`default_nettype wire
